// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port data memory between the LSU (port 0) and DMA (port 1).
// One access per three cycles: IDLE samples requests, ACCESS drives the memory, DONE pulses ack or err.
module data_memory_arbiter #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LAST_ADDR = 32'(4 * MEM_WORDS - 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        last_grant, last_grant_nxt;
  logic        bad, bad_nxt;
  logic        sel;
  logic [31:0] sel_addr;
  logic        own_we;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;

  // On a tie the port that was not granted last wins.
  always_comb begin
    sel = 1'b0;
    if (req0 && req1) sel = ~last_grant;
    else if (req1)    sel = 1'b1;
  end

  assign sel_addr  = sel ? addr1 : addr0;
  assign own_we    = owner ? we1 : we0;
  assign own_addr  = owner ? addr1 : addr0;
  assign own_wdata = owner ? wdata1 : wdata0;

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    bad_nxt        = bad;
    mem_we         = 1'b0;
    mem_addr       = 32'd0;
    mem_wdata      = 32'd0;
    ack0           = 1'b0;
    ack1           = 1'b0;
    err0           = 1'b0;
    err1           = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_nxt      = sel;
          last_grant_nxt = sel;
          bad_nxt        = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_ADDR);
          state_nxt      = bad_nxt ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        // Gating with rst_n keeps a reset edge from committing a half-finished store.
        mem_we    = own_we & rst_n;
        mem_addr  = own_addr;
        mem_wdata = own_wdata;
        state_nxt = DONE;
      end
      DONE: begin
        ack0      = !owner && !bad;
        ack1      =  owner && !bad;
        err0      = !owner &&  bad;
        err1      =  owner &&  bad;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      bad        <= 1'b0;
      rdata0     <= 32'd0;
      rdata1     <= 32'd0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      bad        <= bad_nxt;
      if (state == ACCESS && !own_we) begin
        if (owner) rdata1 <= mem_rdata;
        else       rdata0 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: behavioural memory, scoreboard queue of expected completions, scenario tasks.
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0, we0, ack0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, we1, ack1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  data_memory_arbiter #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input logic [9:0] i);
    return 32'hA5C30000 ^ {6'd0, i, 6'd0, i};
  endfunction

  // Attached memory: untouched words read back a fixed pattern.
  logic [31:0] env_mem [0:1023];
  bit          env_wr  [0:1023];
  always @(posedge clk) begin
    if (mem_we) begin
      env_mem[mem_addr[11:2]] <= mem_wdata;
      env_wr[mem_addr[11:2]]  <= 1'b1;
    end
  end
  always_comb mem_rdata = env_wr[mem_addr[11:2]] ? env_mem[mem_addr[11:2]] : pattern(mem_addr[11:2]);

  int we_cycles = 0;
  int bad_we = 0;
  always @(negedge clk) begin
    if (mem_we) we_cycles++;
    if (mem_we && (mem_addr[1:0] != 2'b00 || mem_addr > 32'hFFC)) bad_we++;
  end

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_mem [0:1023];
  bit          model_wr  [0:1023];
  logic [31:0] exp_rd    [0:1];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_wr[a[11:2]] ? model_mem[a[11:2]] : pattern(a[11:2]);
  endfunction

  task automatic set_port(input bit p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (!p) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else    begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Scoreboard push: called in the order the accesses are expected to be granted.
  task automatic expect_access(input bit p, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.err  = (a[1:0] != 2'b00) || (a > 32'hFFC);
    if (!e.err && w) begin
      model_mem[a[11:2]] = d;
      model_wr[a[11:2]]  = 1'b1;
    end else if (!e.err) begin
      exp_rd[p] = model_read(a);
    end
    e.rdata = exp_rd[p];
    sb.push_back(e);
  endtask

  task automatic wait_done(output bit p, output bit e, output int cyc, output bit timeout);
    p = 1'b0; e = 1'b0; cyc = 0; timeout = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack0 || ack1 || err0 || err1) begin
        p = ack1 || err1;
        e = err0 || err1;
        cyc = i;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1, err0, err1, mem_we} !== 5'd0 || rdata0 !== 0 || rdata1 !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b%b err=%b%b we=%b rdata0=%h rdata1=%h addr=%h wdata=%h, want all 0",
               ack0, ack1, err0, err1, mem_we, rdata0, rdata1, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1, err0, err1, mem_we} !== 5'd0) begin
      errors++;
      $display("FAIL idle_quiet: ack=%b%b err=%b%b we=%b, want 0", ack0, ack1, err0, err1, mem_we);
    end
  endtask

  task automatic test_store_load();
    exp_t got; bit p, e, to; int cyc, w0;
    w0 = we_cycles;
    @(negedge clk);
    expect_access(0, 1, 32'h10, 32'hDEADBEEF);
    set_port(0, 1, 1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_mem_port: we=%b addr=%h wdata=%h, want 1 00000010 deadbeef", mem_we, mem_addr, mem_wdata);
    end
    wait_done(p, e, cyc, to);
    got = sb.pop_front();
    checks++;
    if (to || p !== got.port || e !== got.err || cyc !== 1) begin
      errors++;
      $display("FAIL store_ack: port=%0d err=%0d cyc=%0d timeout=%0d, want port=%0d err=%0d cyc=1", p, e, cyc, to, got.port, got.err);
    end
    expect_access(0, 0, 32'h10, 32'h0);
    set_port(0, 1, 0, 32'h10, 32'h0);
    wait_done(p, e, cyc, to);
    got = sb.pop_front();
    checks++;
    if (to || p !== got.port || e !== got.err || cyc !== 3) begin
      errors++;
      $display("FAIL load_ack: port=%0d err=%0d cyc=%0d timeout=%0d, want port=%0d err=%0d cyc=3", p, e, cyc, to, got.port, got.err);
    end
    checks++;
    if (rdata0 !== got.rdata) begin
      errors++;
      $display("FAIL load_rdata: got %h want %h", rdata0, got.rdata);
    end
    set_port(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (we_cycles - w0 !== 1) begin
      errors++;
      $display("FAIL store_we_cycles: got %0d want 1", we_cycles - w0);
    end
  endtask

  task automatic test_round_robin();
    exp_t got; bit p, e, to; int cyc;
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 6; k++) expect_access(k[0], 0, k[0] ? 32'h204 : 32'h100, 0);
    set_port(0, 1, 0, 32'h100, 0);
    set_port(1, 1, 0, 32'h204, 0);
    for (int k = 0; k < 6; k++) begin
      wait_done(p, e, cyc, to);
      got = sb.pop_front();
      checks++;
      if (to || p !== got.port || e !== got.err || cyc !== (k == 0 ? 2 : 3) || (p ? rdata1 : rdata0) !== got.rdata) begin
        errors++;
        $display("FAIL rr_grant%0d: port=%0d err=%0d cyc=%0d rdata=%h timeout=%0d, want port=%0d err=0 cyc=%0d rdata=%h",
                 k, p, e, cyc, p ? rdata1 : rdata0, to, got.port, k == 0 ? 2 : 3, got.rdata);
      end
    end
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_bad_addr();
    exp_t got; bit p, e, to; int cyc, w0;
    logic [31:0] addrs [0:2];
    int lat [0:2];
    addrs[0] = 32'h1000; addrs[1] = 32'h2; addrs[2] = 32'hFFC;
    lat[0] = 1; lat[1] = 2; lat[2] = 3;
    w0 = we_cycles;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      expect_access(1, 0, addrs[k], 0);
      set_port(1, 1, 0, addrs[k], 0);
      wait_done(p, e, cyc, to);
      got = sb.pop_front();
      checks++;
      if (to || p !== got.port || e !== got.err || ack1 === got.err || cyc !== lat[k]) begin
        errors++;
        $display("FAIL bad_addr_%h: port=%0d err=%0d ack1=%b cyc=%0d timeout=%0d, want port=1 err=%0d cyc=%0d",
                 addrs[k], p, e, ack1, cyc, to, got.err, lat[k]);
      end
      checks++;
      if (rdata1 !== got.rdata) begin
        errors++;
        $display("FAIL bad_addr_rdata_%h: got %h want %h", addrs[k], rdata1, got.rdata);
      end
    end
    set_port(1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (we_cycles - w0 !== 0) begin
      errors++;
      $display("FAIL bad_addr_we: got %0d write cycles want 0", we_cycles - w0);
    end
  endtask

  task automatic test_reset_mid_access();
    exp_t got; bit p, e, to; int cyc;
    @(negedge clk);
    set_port(0, 1, 1, 32'hFFC, 32'h12345678);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'hFFC) begin
      errors++;
      $display("FAIL abort_pre: we=%b addr=%h, want 1 00000ffc", mem_we, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_we_gate: got %b want 0", mem_we);
    end
    @(negedge clk);
    set_port(0, 0, 0, 0, 0);
    checks++;
    if ({ack0, ack1, err0, err1, mem_we} !== 5'd0 || rdata0 !== 0 || rdata1 !== 0 || mem_addr !== 0 || env_wr[1023]) begin
      errors++;
      $display("FAIL abort_outputs: ack=%b%b err=%b%b we=%b rdata=%h/%h addr=%h word1023_written=%0d, want all 0",
               ack0, ack1, err0, err1, mem_we, rdata0, rdata1, mem_addr, env_wr[1023]);
    end
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    rst_n = 1'b1;
    expect_access(0, 0, 32'h20, 0);
    expect_access(1, 0, 32'h24, 0);
    set_port(0, 1, 0, 32'h20, 0);
    set_port(1, 1, 0, 32'h24, 0);
    for (int k = 0; k < 2; k++) begin
      wait_done(p, e, cyc, to);
      got = sb.pop_front();
      checks++;
      if (to || p !== got.port || e !== got.err || (p ? rdata1 : rdata0) !== got.rdata) begin
        errors++;
        $display("FAIL tie_after_reset%0d: port=%0d err=%0d rdata=%h timeout=%0d, want port=%0d err=0 rdata=%h",
                 k, p, e, p ? rdata1 : rdata0, to, got.port, got.rdata);
      end
      set_port(p, 0, 0, 0, 0);
    end
    @(negedge clk);
  endtask

  task automatic test_preempt();
    exp_t got; bit p, e, to; int cyc;
    @(negedge clk);
    expect_access(1, 0, 32'h40, 0);
    set_port(1, 1, 0, 32'h40, 0);
    @(negedge clk);
    expect_access(0, 0, 32'h80, 0);
    set_port(0, 1, 0, 32'h80, 0);
    wait_done(p, e, cyc, to);
    got = sb.pop_front();
    checks++;
    if (to || p !== got.port || e !== got.err || cyc !== 1 || rdata1 !== got.rdata) begin
      errors++;
      $display("FAIL preempt_port1: port=%0d err=%0d cyc=%0d rdata1=%h timeout=%0d, want port=1 err=0 cyc=1 rdata1=%h",
               p, e, cyc, rdata1, to, got.rdata);
    end
    set_port(1, 0, 0, 0, 0);
    wait_done(p, e, cyc, to);
    got = sb.pop_front();
    checks++;
    if (to || p !== got.port || e !== got.err || cyc !== 3 || rdata0 !== got.rdata) begin
      errors++;
      $display("FAIL preempt_port0: port=%0d err=%0d cyc=%0d rdata0=%h timeout=%0d, want port=0 err=0 cyc=3 rdata0=%h",
               p, e, cyc, rdata0, to, got.rdata);
    end
    checks++;
    if (rdata1 !== exp_rd[1]) begin
      errors++;
      $display("FAIL preempt_rdata1_kept: got %h want %h", rdata1, exp_rd[1]);
    end
    set_port(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    test_reset();
    test_store_load();
    test_round_robin();
    test_bad_addr();
    test_reset_mid_access();
    test_preempt();
    checks++;
    if (bad_we !== 0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL final_state: illegal writes=%0d leftover expectations=%0d, want 0 and 0", bad_we, sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
